// File: rtl/can_pkg.sv
// Shared constants, state encoding and frame payload for the CAN transmit path.
`timescale 1ns/1ps
package can_pkg;

  localparam logic [14:0] CRC_POLY = 15'h4599;

  localparam int unsigned ID_LEN  = 11;
  localparam int unsigned DLC_LEN = 4;
  localparam int unsigned CRC_LEN = 15;
  localparam int unsigned EOF_LEN = 7;
  // Wide enough to index the 64 data bits.
  localparam int unsigned CNT_W   = 6;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SOF,
    ST_ID,
    ST_RTR,
    ST_IDE,
    ST_R0,
    ST_DLC,
    ST_DATA,
    ST_CRC,
    ST_CRC_DEL,
    ST_ACK_SLOT,
    ST_ACK_DEL,
    ST_EOF,
    ST_IFS
  } state_e;

  typedef struct packed {
    logic [10:0] id;
    logic        rtr;
    logic [3:0]  dlc;
    logic [63:0] data;
  } frame_t;

endpackage

// File: rtl/can_tx_crc.sv
// CRC-15 shift register: one step per unstuffed frame bit.
`timescale 1ns/1ps
module can_tx_crc
  import can_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        shift_en,
  input  logic        din,
  output logic [14:0] crc
);

  logic fb;

  assign fb = din ^ crc[14];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc <= '0;
    end else if (clear) begin
      crc <= '0;
    end else if (shift_en) begin
      crc <= {crc[13:0], 1'b0} ^ (fb ? CRC_POLY : 15'h0000);
    end
  end

endmodule

// File: rtl/can_tx_frame.sv
// CAN 2.0A frame transmitter: field sequencing, bit stuffing, CRC, arbitration and ACK check.
`timescale 1ns/1ps
module can_tx_frame
  import can_pkg::*;
#(
  parameter int unsigned IFS_BITS = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bit_tick,
  input  logic        start,
  input  logic [10:0] id,
  input  logic        rtr,
  input  logic [3:0]  dlc,
  input  logic [63:0] data,
  input  logic        rx,
  output logic        tx,
  output logic        busy,
  output logic        done,
  output logic        ack_err,
  output logic        arb_lost
);

  state_e           state_q, state_d, adv_state;
  logic [CNT_W-1:0] cnt_q, cnt_d, adv_cnt;
  logic [2:0]       run_q, run_d;
  frame_t           frm_q, frm_d;
  logic             tx_d, busy_d, done_d, ack_err_d, arb_lost_d;
  logic             fin, nxt_bit, stuff_zone;
  logic             crc_clear, crc_shift, crc_din;
  logic [14:0]      crc;
  logic [3:0]       nbytes;
  logic [6:0]       data_bits;
  logic             has_data;

  can_tx_crc u_crc (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (crc_clear),
    .shift_en (crc_shift),
    .din      (crc_din),
    .crc      (crc)
  );

  assign nbytes     = (frm_q.dlc > 4'd8) ? 4'd8 : frm_q.dlc;
  assign data_bits  = {nbytes, 3'b000};
  assign has_data   = !frm_q.rtr && (nbytes != 4'd0);
  assign stuff_zone = state_q inside {ST_SOF, ST_ID, ST_RTR, ST_IDE, ST_R0, ST_DLC, ST_DATA, ST_CRC};

  // Field position that follows the current non-stuff bit; fin marks the last IFS bit.
  always_comb begin
    adv_state = state_q;
    adv_cnt   = '0;
    fin       = 1'b0;
    unique case (state_q)
      ST_SOF:      adv_state = ST_ID;
      ST_ID:       if (cnt_q == CNT_W'(ID_LEN - 1)) adv_state = ST_RTR;
                   else adv_cnt = cnt_q + CNT_W'(1);
      ST_RTR:      adv_state = ST_IDE;
      ST_IDE:      adv_state = ST_R0;
      ST_R0:       adv_state = ST_DLC;
      ST_DLC:      if (cnt_q == CNT_W'(DLC_LEN - 1)) adv_state = has_data ? ST_DATA : ST_CRC;
                   else adv_cnt = cnt_q + CNT_W'(1);
      ST_DATA:     if (({1'b0, cnt_q} + 7'd1) == data_bits) adv_state = ST_CRC;
                   else adv_cnt = cnt_q + CNT_W'(1);
      ST_CRC:      if (cnt_q == CNT_W'(CRC_LEN - 1)) adv_state = ST_CRC_DEL;
                   else adv_cnt = cnt_q + CNT_W'(1);
      ST_CRC_DEL:  adv_state = ST_ACK_SLOT;
      ST_ACK_SLOT: adv_state = ST_ACK_DEL;
      ST_ACK_DEL:  adv_state = ST_EOF;
      ST_EOF:      if (cnt_q == CNT_W'(EOF_LEN - 1)) begin
                     if (IFS_BITS == 0) fin = 1'b1;
                     else adv_state = ST_IFS;
                   end else adv_cnt = cnt_q + CNT_W'(1);
      ST_IFS:      if (cnt_q == CNT_W'(IFS_BITS - 1)) fin = 1'b1;
                   else adv_cnt = cnt_q + CNT_W'(1);
      default:     adv_state = ST_SOF;
    endcase
  end

  // Bus level for the field position being entered.
  always_comb begin
    nxt_bit = 1'b1;
    unique case (adv_state)
      ST_SOF, ST_IDE, ST_R0: nxt_bit = 1'b0;
      ST_ID:   nxt_bit = frm_q.id[4'(ID_LEN - 1) - adv_cnt[3:0]];
      ST_RTR:  nxt_bit = frm_q.rtr;
      ST_DLC:  nxt_bit = frm_q.dlc[2'(DLC_LEN - 1) - adv_cnt[1:0]];
      ST_DATA: nxt_bit = frm_q.data[~adv_cnt];
      ST_CRC:  nxt_bit = crc[4'(CRC_LEN - 1) - adv_cnt[3:0]];
      default: nxt_bit = 1'b1;
    endcase
  end

  // IDLE with busy set means a frame is armed and waits for the next bit boundary.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    run_d      = run_q;
    frm_d      = frm_q;
    tx_d       = tx;
    busy_d     = busy;
    done_d     = 1'b0;
    ack_err_d  = ack_err;
    arb_lost_d = 1'b0;
    crc_clear  = 1'b0;
    crc_shift  = 1'b0;
    crc_din    = nxt_bit;
    if (state_q == ST_IDLE && !busy) begin
      if (start) begin
        frm_d.id   = id;
        frm_d.rtr  = rtr;
        frm_d.dlc  = dlc;
        frm_d.data = data;
        busy_d     = 1'b1;
        ack_err_d  = 1'b0;
        crc_clear  = 1'b1;
      end
    end else if (bit_tick) begin
      if ((state_q == ST_ID || state_q == ST_RTR) && tx && !rx) begin
        state_d    = ST_IDLE;
        cnt_d      = '0;
        run_d      = '0;
        tx_d       = 1'b1;
        busy_d     = 1'b0;
        arb_lost_d = 1'b1;
      end else if (stuff_zone && run_q == 3'd5) begin
        tx_d  = ~tx;
        run_d = 3'd1;
      end else if (fin) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        run_d   = '0;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end else begin
        if (state_q == ST_ACK_SLOT && rx) ack_err_d = 1'b1;
        state_d   = adv_state;
        cnt_d     = adv_cnt;
        tx_d      = nxt_bit;
        run_d     = (nxt_bit == tx) ? ((run_q == 3'd7) ? run_q : run_q + 3'd1) : 3'd1;
        crc_shift = adv_state inside {ST_SOF, ST_ID, ST_RTR, ST_IDE, ST_R0, ST_DLC, ST_DATA};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      run_q    <= '0;
      frm_q    <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      ack_err  <= 1'b0;
      arb_lost <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      run_q    <= run_d;
      frm_q    <= frm_d;
      tx       <= tx_d;
      busy     <= busy_d;
      done     <= done_d;
      ack_err  <= ack_err_d;
      arb_lost <= arb_lost_d;
    end
  end

endmodule

// File: tb/tb_can_tx_frame.sv
// Randomized scoreboard bench for can_tx_frame with a list-based frame reference model.
`timescale 1ns/1ps
module tb_can_tx_frame;

  localparam int IFS        = 3;
  localparam int MODE_ACK   = 0;
  localparam int MODE_NOACK = 1;
  localparam int MODE_ARB   = 2;

  typedef struct {
    logic [255:0] bits;
    int           len;
    bit           exp_done;
    bit           exp_arb;
    bit           exp_ack;
    int           crc_end;
    int           force_i;
  } exp_t;

  logic        clk, rst_n, bit_tick, start, rtr, rx;
  logic [10:0] id;
  logic [3:0]  dlc;
  logic [63:0] data;
  logic        tx, busy, done, ack_err, arb_lost;

  int   checks = 0;
  int   errors = 0;
  int   force_idx = -1;
  int   tick_cnt = 0;
  bit   prev_ack = 1'b0;
  exp_t sb[$];

  can_tx_frame #(.IFS_BITS(IFS)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bit_tick (bit_tick),
    .start    (start),
    .id       (id),
    .rtr      (rtr),
    .dlc      (dlc),
    .data     (data),
    .rx       (rx),
    .tx       (tx),
    .busy     (busy),
    .done     (done),
    .ack_err  (ack_err),
    .arb_lost (arb_lost)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One bit_tick every fourth clock.
  initial begin
    bit_tick = 1'b0;
    forever begin
      @(negedge clk);
      tick_cnt = (tick_cnt == 3) ? 0 : tick_cnt + 1;
      bit_tick = (tick_cnt == 0);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [14:0] crc_step(input logic [14:0] c, input logic b);
    logic n;
    n = b ^ c[14];
    return {c[13:0], 1'b0} ^ (n ? 15'h4599 : 15'h0000);
  endfunction

  // Expected tx sequence observed after each bit_tick, from SOF to the first idle bit.
  task automatic model(input logic [10:0] fid, input logic frtr, input logic [3:0] fdlc,
                       input logic [63:0] fdata, input int mode, input int arb_u, output exp_t e);
    bit ub[$];
    bit st[$];
    int umap[$];
    logic [14:0] c;
    int nb, run, ack_i, keep;
    bit last;
    ub.push_back(1'b0);
    for (int i = 10; i >= 0; i--) ub.push_back(fid[i]);
    ub.push_back(frtr);
    ub.push_back(1'b0);
    ub.push_back(1'b0);
    for (int i = 3; i >= 0; i--) ub.push_back(fdlc[i]);
    nb = frtr ? 0 : ((fdlc > 8) ? 8 : int'(fdlc));
    for (int i = 0; i < nb * 8; i++) ub.push_back(fdata[63 - i]);
    c = '0;
    foreach (ub[i]) c = crc_step(c, ub[i]);
    for (int i = 14; i >= 0; i--) ub.push_back(c[i]);
    e.crc_end = ub.size();
    run = 0;
    last = 1'b0;
    foreach (ub[i]) begin
      if (run == 5) begin
        last = !last;
        st.push_back(last);
        run = 1;
      end
      umap.push_back(st.size());
      st.push_back(ub[i]);
      if (run > 0 && ub[i] == last) run++;
      else run = 1;
      last = ub[i];
    end
    if (run == 5) st.push_back(!last);
    st.push_back(1'b1);
    ack_i = st.size();
    for (int i = 0; i < 2 + 7 + IFS + 1; i++) st.push_back(1'b1);
    e.exp_done = (mode != MODE_ARB);
    e.exp_arb  = (mode == MODE_ARB);
    e.exp_ack  = (mode == MODE_NOACK);
    e.force_i  = (mode == MODE_ACK) ? ack_i : -1;
    if (mode == MODE_ARB) begin
      keep = umap[arb_u] + 1;
      while (st.size() > keep) void'(st.pop_back());
      st.push_back(1'b1);
      e.force_i = umap[arb_u];
    end
    e.len  = st.size();
    e.bits = '0;
    foreach (st[i]) e.bits[i] = st[i];
  endtask

  // Monitor: records tx after every bit boundary and scores the frame when busy drops.
  initial begin
    logic t, bp, txp, b, last;
    logic [255:0] got_bits;
    logic [14:0] c;
    int got_len, n, run, i;
    exp_t e;
    got_len = 0;
    got_bits = '0;
    rx = 1'b1;
    forever begin
      @(posedge clk);
      t = bit_tick;
      bp = busy;
      txp = tx;
      #1;
      if (!rst_n) begin
        got_len = 0;
        got_bits = '0;
        rx = 1'b1;
      end else begin
        if (!t) begin
          checks++;
          if (tx !== txp) begin
            errors++;
            $display("FAIL tx_between_ticks: got %b, required %b", tx, txp);
          end
        end
        if (t && bp && got_len < 256) begin
          got_bits[got_len] = tx;
          got_len++;
        end
        if (bp && !busy) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_frame: got frame of %0d bits, required none", got_len);
          end else begin
            e = sb.pop_front();
            if (got_len != e.len || got_bits !== e.bits) begin
              errors++;
              $display("FAIL stream: got len=%0d bits=%h, required len=%0d bits=%h",
                       got_len, got_bits, e.len, e.bits);
            end
            checks++;
            if (done !== e.exp_done || arb_lost !== e.exp_arb) begin
              errors++;
              $display("FAIL end_pulses: got done=%b arb_lost=%b, required done=%b arb_lost=%b",
                       done, arb_lost, e.exp_done, e.exp_arb);
            end
            if (e.exp_done) begin
              checks++;
              if (ack_err !== e.exp_ack) begin
                errors++;
                $display("FAIL ack_err_at_done: got %b, required %b", ack_err, e.exp_ack);
              end
              c = '0; n = 0; run = 0; last = 1'b0; i = 0;
              while (n < e.crc_end && i < got_len) begin
                b = got_bits[i];
                i++;
                if (run == 5) begin
                  run = 1;
                  last = b;
                end else begin
                  c = crc_step(c, b);
                  n++;
                  if (run > 0 && b == last) run++;
                  else run = 1;
                  last = b;
                end
              end
              checks++;
              if (c !== 15'h0 || n != e.crc_end) begin
                errors++;
                $display("FAIL crc_residue: got %h over %0d bits, required 0000 over %0d bits",
                         c, n, e.crc_end);
              end
            end
          end
          got_len = 0;
          got_bits = '0;
        end else begin
          checks++;
          if (done !== 1'b0 || arb_lost !== 1'b0) begin
            errors++;
            $display("FAIL stray_pulse: got done=%b arb_lost=%b, required 0 0", done, arb_lost);
          end
        end
        rx = (busy && got_len > 0 && (got_len - 1) == force_idx) ? 1'b0 : tx;
      end
    end
  end

  task automatic check_idle_outputs(input string name);
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || ack_err !== 1'b0 || arb_lost !== 1'b0) begin
      errors++;
      $display("FAIL %s: got tx=%b busy=%b done=%b ack_err=%b arb_lost=%b, required 1 0 0 0 0",
               name, tx, busy, done, ack_err, arb_lost);
    end
  endtask

  task automatic send_frame(input logic [10:0] fid, input logic frtr, input logic [3:0] fdlc,
                            input logic [63:0] fdata, input int mode, input int arb_u,
                            input bit coinc, input bit abort);
    exp_t e;
    int k;
    model(fid, frtr, fdlc, fdata, mode, arb_u, e);
    checks++;
    if (ack_err !== prev_ack) begin
      errors++;
      $display("FAIL ack_err_held: got %b, required %b", ack_err, prev_ack);
    end
    force_idx = abort ? -1 : e.force_i;
    if (!abort) sb.push_back(e);
    if (coinc) begin
      k = 0;
      do begin
        @(negedge clk);
        #1;
        k++;
      end while (!bit_tick && k < 20);
    end else begin
      @(negedge clk);
      #1;
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    id = fid; rtr = frtr; dlc = fdlc; data = fdata;
    start = 1'b1;
    @(negedge clk);
    #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || ack_err !== 1'b0) begin
      errors++;
      $display("FAIL accept: got busy=%b ack_err=%b, required 1 0", busy, ack_err);
    end
    if ($urandom_range(0, 1) == 1) begin
      repeat (3) @(negedge clk);
      id = 11'($urandom); dlc = 4'($urandom); rtr = 1'($urandom); data = {$urandom, $urandom};
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    if (abort) begin
      k = 0;
      while (k < 30) begin
        @(posedge clk);
        if (bit_tick) k++;
      end
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_idle_outputs("reset_mid_frame");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      prev_ack = 1'b0;
    end else begin
      k = 0;
      while (busy && k < 4000) begin
        @(negedge clk);
        k++;
      end
      if (busy) begin
        checks++;
        errors++;
        $display("FAIL frame_timeout: got busy=1 after %0d clocks, required 0", k);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
        prev_ack = 1'b0;
      end else begin
        prev_ack = e.exp_ack;
      end
    end
    repeat ($urandom_range(1, 4)) @(negedge clk);
  endtask

  initial begin
    logic [10:0] rid;
    logic        rrtr;
    logic [3:0]  rdlc;
    logic [63:0] rdata;
    int          mode, p, tries;
    bit          bv;
    rst_n = 1'b0; start = 1'b0; id = '0; rtr = 1'b0; dlc = '0; data = '0;
    repeat (3) @(negedge clk);
    #1;
    check_idle_outputs("reset_state");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    send_frame(11'h555, 1'b0, 4'd0, 64'h0, MODE_ACK, -1, 1'b0, 1'b0);
    send_frame(11'h000, 1'b0, 4'd0, 64'h0, MODE_ACK, -1, 1'b1, 1'b0);
    send_frame(11'h123, 1'b0, 4'd8, 64'h0011_2233_4455_6677, MODE_ACK, -1, 1'b0, 1'b0);
    send_frame(11'h555, 1'b0, 4'd2, 64'hA5A5_0000_0000_0000, MODE_ARB, 7, 1'b0, 1'b0);
    send_frame(11'h2F1, 1'b0, 4'd3, 64'hDEAD_BEEF_0000_0000, MODE_NOACK, -1, 1'b0, 1'b0);
    send_frame(11'h321, 1'b0, 4'd8, 64'hFFFF_0000_FFFF_0000, MODE_ACK, -1, 1'b0, 1'b1);
    send_frame(11'h0F0, 1'b1, 4'd4, 64'h0, MODE_ACK, -1, 1'b0, 1'b0);
    send_frame(11'h7FF, 1'b0, 4'd15, 64'hFFFF_FFFF_FFFF_FFFF, MODE_ACK, -1, 1'b0, 1'b0);

    for (int f = 0; f < 24; f++) begin
      rid = 11'($urandom);
      rrtr = ($urandom_range(0, 3) == 0);
      rdlc = 4'($urandom_range(0, 15));
      rdata = {$urandom, $urandom};
      mode = $urandom_range(0, 3);
      if (mode == 3) mode = MODE_ARB;
      else if (mode == 2) mode = MODE_NOACK;
      else mode = MODE_ACK;
      p = -1;
      if (mode == MODE_ARB) begin
        p = $urandom_range(1, 12);
        tries = 0;
        bv = (p <= 11) ? rid[11 - p] : rrtr;
        while (!bv && tries < 12) begin
          p = (p == 12) ? 1 : p + 1;
          bv = (p <= 11) ? rid[11 - p] : rrtr;
          tries++;
        end
        if (!bv) begin
          mode = MODE_ACK;
          p = -1;
        end
      end
      send_frame(rid, rrtr, rdlc, rdata, mode, p, ($urandom_range(0, 3) == 0), 1'b0);
    end

    repeat (10) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending frames, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/can_tx_frame.md
CAN_TX_FRAME -- requirements
Module: can_tx_frame

Interface
REQ-001 IFS_BITS, default 3, number of recessive intermission bits sent after EOF before the block returns to idle.
REQ-002 clk  in  1  system clock, 100 MHz.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 bit_tick  in  1  one-clk pulse marking each CAN bit boundary.
REQ-005 start  in  1  request to send one frame; sampled on any clk edge.
REQ-006 id  in  11  standard identifier, MSB sent first.
REQ-007 rtr  in  1  1 = remote frame.
REQ-008 dlc  in  4  data length code.
REQ-009 data  in  64  payload; byte 0 = data[63:56], MSB first.
REQ-010 rx  in  1  bus level, valid at bit_tick.
REQ-011 tx  out  1  bus drive; 0 = dominant, 1 = recessive.
REQ-012 busy  out  1  high from accepted start until return to IDLE.
REQ-013 done  out  1  one-clk pulse on completion of IFS.
REQ-014 ack_err  out  1  no ACK seen; valid while done is high, held until the next accepted start.
REQ-015 arb_lost  out  1  one-clk pulse when arbitration is lost.

Function
REQ-016 States: IDLE, SOF, ID, RTR, IDE, R0, DLC, DATA, CRC, CRC_DEL, ACK_SLOT, ACK_DEL, EOF, IFS; a field counter tracks the bit index within the current field.
REQ-017 In IDLE, start SHALL latch id/rtr/dlc/data and set busy on the next clk; start while busy is ignored.
REQ-018 At each bit_tick the block SHALL sample rx for the bit being driven, then update tx to the next bit; tx changes only on bit_tick.
REQ-019 If start and bit_tick coincide in IDLE, SOF is driven on the following bit_tick, not the coincident one.
REQ-020 Field bits: SOF=0, ID 11 bits, RTR=rtr, IDE=0, r0=0, DLC 4 bits as given.
REQ-021 DATA is sent only when rtr=0; the number of bytes sent is min(dlc,8); dlc>8 is sent unchanged in the DLC field.
REQ-022 CRC-15: register initialised to 0 at SOF; for each unstuffed bit b from SOF through the last data bit, nxt=b^crc[14], crc=(crc<<1)^(nxt?0x4599:0); the CRC field is sent MSB first.
REQ-023 Bit stuffing applies from SOF through the last CRC bit: after 5 consecutive equal transmitted bits, one complement bit SHALL be inserted.
REQ-024 Stuff bits are counted in the run of equal bits; they do not feed the CRC or advance the field counter.
REQ-025 No stuffing is applied from CRC_DEL onward; CRC_DEL, ACK_SLOT, ACK_DEL, EOF (7 bits) and IFS are all recessive.
REQ-026 Arbitration: in ID or RTR, if tx=1 and rx=0 at bit_tick, the block SHALL set tx=1, pulse arb_lost, clear busy and enter IDLE without pulsing done.
REQ-027 ACK: rx=1 sampled during ACK_SLOT SHALL set ack_err; the frame still completes.
REQ-028 After IFS, the block SHALL pulse done, clear busy and enter IDLE.

Reset
REQ-029 While rst_n=0: tx=1, busy=0, done=0, ack_err=0, arb_lost=0, CRC=0, stuff counter=0, state=IDLE.
REQ-030 Reset asserted mid-frame SHALL abort the frame immediately with no done or arb_lost pulse.

Structure
REQ-031 Shared package can_pkg SHALL hold CRC_POLY=15'h4599, the state enumeration and field length constants (ID=11, DLC=4, CRC=15, EOF=7).
REQ-032 The CRC step SHALL be a sub-module can_tx_crc with clear, shift-enable and bit inputs and a 15-bit output.

Verification
REQ-033 id=0x555, rtr=0, dlc=0, rx follows tx except during ACK_SLOT (rx=0) -> stuff bit 1 appears after DLC[2]; ack_err=0; done pulses once.
REQ-034 id=0x000, rtr=0, dlc=0 -> stuff bit 1 inserted after ID[7] (SOF plus 4 zeros); destuffed stream matches the expected field bits.
REQ-035 id=0x123, dlc=8, data=0x0011223344556677 -> running REQ-022 over the destuffed SOF..CRC bits gives 0; unstuffed length from SOF to EOF is 108 bits.
REQ-036 rx forced 0 on ID[4] while tx=1 -> arb_lost pulses, tx=1 thereafter, busy=0, no done.
REQ-037 rx held 1 during ACK_SLOT -> ack_err=1 while done is high; next start clears ack_err.
REQ-038 rst_n pulsed low during DATA, then start issued -> tx=1 immediately; the new frame begins cleanly with SOF.
